seq_addsub16: RTL

Multi-cycle 16-bit saturating adder/subtractor for the ALU datapath. It produces a full-width result by driving one 4-bit add/sub slice over four consecutive cycles, least-significant nibble first. It sits directly upstream of the 4-bit slice: it feeds the slice its operands and carry, and collects its results. It exposes a start/busy/done handshake to the execute stage, plus Z/N/V flags for the flag register.

---
 rtl/seq_addsub16_pkg.sv | 18 +
 rtl/seq_addsub16_if.sv | 26 ++
 rtl/seq_addsub16_nibble.sv | 24 ++
 rtl/seq_addsub16.sv | 114 +++++++++++
 4 files changed

// File: rtl/seq_addsub16_pkg.sv
// Shared types and constants for the nibble-serial 16-bit add/sub datapath.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = 4;

  localparam logic [1:0]        LAST_IDX = 2'(NUM_NIB - 1);
  localparam logic [DATA_W-1:0] SAT_POS  = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG  = 16'h8000;

endpackage

// File: rtl/seq_addsub16_if.sv
// Start/busy/done handshake, operands and result/flags between execute stage and seq_addsub16.
interface seq_addsub16_if;

  logic                          start;
  logic [addsub_pkg::DATA_W-1:0] a;
  logic [addsub_pkg::DATA_W-1:0] b;
  logic                          is_sub;
  logic                          busy;
  logic                          done;
  logic [addsub_pkg::DATA_W-1:0] sum;
  logic                          ovfl;
  logic                          flag_z;
  logic                          flag_n;
  logic                          flag_v;

  modport master (
    output start, a, b, is_sub,
    input  busy, done, sum, ovfl, flag_z, flag_n, flag_v
  );

  modport slave (
    input  start, a, b, is_sub,
    output busy, done, sum, ovfl, flag_z, flag_n, flag_v
  );

endinterface

// File: rtl/seq_addsub16_nibble.sv
// Combinational 4-bit adder slice; also exposes the carry into its MSB for overflow detection.
module add_nibble
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W:0]   full;
  logic [NIB_W-1:0] low;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    low  = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};
    s    = full[NIB_W-1:0];
    cout = full[NIB_W];
    c3   = low[NIB_W-1];
  end

endmodule

// File: rtl/seq_addsub16.sv
// Multi-cycle 16-bit saturating add/sub: one 4-bit slice reused over four cycles, LS nibble first.
module seq_addsub16
  import addsub_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  seq_addsub16_if.slave bus
);

  state_t state, state_next;

  logic [1:0]        idx;
  logic              carry;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              is_sub_q;
  logic [DATA_W-1:0] result;
  logic              ovfl_q;
  logic              flag_z_q;
  logic              flag_n_q;

  logic              accept;
  logic [NIB_W-1:0]  nib_a;
  logic [NIB_W-1:0]  nib_b;
  logic [NIB_W-1:0]  nib_s;
  logic              nib_cout;
  logic              nib_c3;
  logic              last;
  logic              v;
  logic [DATA_W-1:0] full_sum;
  logic [DATA_W-1:0] final_sum;

  add_nibble u_nibble (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  always_comb begin
    accept     = bus.start && (state == IDLE || state == DONE);
    last       = (idx == LAST_IDX);
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: operand B is inverted per nibble, the +1 enters as the initial carry.
  always_comb begin
    nib_a     = a_q[{idx, 2'b00} +: NIB_W];
    nib_b     = b_q[{idx, 2'b00} +: NIB_W] ^ {NIB_W{is_sub_q}};
    full_sum  = {nib_s, result[DATA_W-NIB_W-1:0]};
    v         = nib_c3 ^ nib_cout;
    final_sum = full_sum;
    if (SATURATE && v)
      final_sum = a_q[DATA_W-1] ? SAT_NEG : SAT_POS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      is_sub_q <= 1'b0;
      result   <= '0;
      ovfl_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      is_sub_q <= bus.is_sub;
      result   <= '0;
      idx      <= '0;
      carry    <= bus.is_sub;
    end else if (state == RUN) begin
      carry <= nib_cout;
      idx   <= idx + 2'd1;
      if (last) begin
        result   <= final_sum;
        ovfl_q   <= v;
        flag_z_q <= (final_sum == '0);
        flag_n_q <= final_sum[DATA_W-1];
      end else begin
        result[{idx, 2'b00} +: NIB_W] <= nib_s;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.sum    = result;
  assign bus.ovfl   = ovfl_q;
  assign bus.flag_v = ovfl_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;

endmodule
